// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, FSM encoding and range helper for the memory access controller
package mem_pkg;

   localparam int MEM_ADDR_W = 9;
   localparam int MEM_DATA_W = 32;
   localparam int MEM_DEPTH  = 1 << MEM_ADDR_W;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   // True when any bit above the RAM word index is set in a 32-bit word address.
   function automatic logic addr_out_of_range(input logic [31:0] addr, input int addr_w);
      logic [31:0] mask;
      mask = ~((32'd1 << addr_w) - 32'd1);
      return (addr & mask) != 32'd0;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - CPU request/response and RAM pin bundle for the memory access controller
interface mem_access_ctrl_if
   import mem_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
);

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [31:0]       req_addr;
   logic [DATA_W-1:0] req_wdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   logic              ram_read;
   logic              ram_write;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic [DATA_W-1:0] ram_dout;

   // Controller side: serves the CPU and drives the RAM pins.
   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready, ram_dout,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output ram_read, ram_write, ram_addr, ram_din
   );

   // CPU plus RAM side, as seen by whatever surrounds the controller.
   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready, ram_dout,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  ram_read, ram_write, ram_addr, ram_din
   );

endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-outstanding load/store controller with MAR/MDR in front of a sync-read RAM
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_W      = MEM_ADDR_W,
   parameter int DATA_W      = MEM_DATA_W,
   parameter bit CHECK_RANGE = 1'b1
) (
   input logic              clock,
   input logic              clear,
   mem_access_ctrl_if.slave bus
);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] mar;
   logic [DATA_W-1:0] mdr;
   logic              wr_q;
   logic              err_q;
   logic              range_err;

   assign range_err = CHECK_RANGE && addr_out_of_range(bus.req_addr, ADDR_W);

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state <= IDLE;
         mar   <= '0;
         mdr   <= '0;
         wr_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  mar   <= bus.req_addr[ADDR_W-1:0];
                  mdr   <= bus.req_wdata;
                  wr_q  <= bus.req_write;
                  err_q <= range_err;
               end
            end
            ISSUE: begin
               if (wr_q) begin
                  mdr <= '0;
               end
            end
            // RAM registered its output at the ISSUE edge; take it now.
            CAPTURE: mdr <= bus.ram_dout;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               state_nxt = range_err ? RESP : ISSUE;
            end
         end
         ISSUE:   state_nxt = wr_q ? RESP : CAPTURE;
         CAPTURE: state_nxt = RESP;
         RESP: begin
            if (bus.rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Every output below is a decode of registered state, so the reset
   // clears the RAM strobes without waiting for a clock edge.
   always_comb begin
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_rdata = '0;
      bus.rsp_err   = 1'b0;
      bus.ram_read  = 1'b0;
      bus.ram_write = 1'b0;
      bus.ram_addr  = mar;
      bus.ram_din   = '0;
      case (state)
         IDLE: bus.req_ready = 1'b1;
         ISSUE: begin
            bus.ram_write = wr_q;
            bus.ram_read  = ~wr_q;
            bus.ram_din   = mdr;
         end
         CAPTURE: bus.ram_read = 1'b1;
         RESP: begin
            bus.rsp_valid = 1'b1;
            bus.rsp_err   = err_q;
            bus.rsp_rdata = (err_q || wr_q) ? '0 : mdr;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed scoreboard bench for mem_access_ctrl with behavioural 512x32 RAMs
module tb_mem_access_ctrl;
   import mem_pkg::*;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic        sel = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_ready = 1'b0;
   bit          ram_init = 1'b1;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];

   logic [31:0] ram0 [512];
   logic [31:0] ram1 [512];
   logic [31:0] ram0_dout;
   logic [31:0] ram1_dout;
   logic [31:0] model0 [512];
   logic [31:0] model1 [512];

   int          wr_cnt = 0;
   int          rd_cnt = 0;
   logic [8:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;

   mem_access_ctrl_if #(.ADDR_W(9), .DATA_W(32)) if0 ();
   mem_access_ctrl_if #(.ADDR_W(9), .DATA_W(32)) if1 ();

   mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .CHECK_RANGE(1'b1)) dut0 (
      .clock(clock), .clear(clear), .bus(if0.slave)
   );
   mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .CHECK_RANGE(1'b0)) dut1 (
      .clock(clock), .clear(clear), .bus(if1.slave)
   );

   always #5 clock = ~clock;

   assign if0.req_valid = req_valid & ~sel;
   assign if0.req_write = req_write;
   assign if0.req_addr  = req_addr;
   assign if0.req_wdata = req_wdata;
   assign if0.rsp_ready = rsp_ready;
   assign if0.ram_dout  = ram0_dout;
   assign if1.req_valid = req_valid & sel;
   assign if1.req_write = req_write;
   assign if1.req_addr  = req_addr;
   assign if1.req_wdata = req_wdata;
   assign if1.rsp_ready = rsp_ready;
   assign if1.ram_dout  = ram1_dout;

   logic        o_req_ready, o_rsp_valid, o_rsp_err;
   logic [31:0] o_rsp_rdata;
   assign o_req_ready = sel ? if1.req_ready : if0.req_ready;
   assign o_rsp_valid = sel ? if1.rsp_valid : if0.rsp_valid;
   assign o_rsp_err   = sel ? if1.rsp_err   : if0.rsp_err;
   assign o_rsp_rdata = sel ? if1.rsp_rdata : if0.rsp_rdata;

   function automatic logic [31:0] init0(input int i);
      return (i == 511) ? 32'h1234_5678 : (32'h1000_0000 | 32'(i));
   endfunction

   function automatic logic [31:0] init1(input int i);
      return 32'hA5A5_0000 | 32'(i);
   endfunction

   always @(posedge clock) begin
      if (ram_init) begin
         for (int i = 0; i < 512; i++) begin
            ram0[i] <= init0(i);
            ram1[i] <= init1(i);
         end
      end else begin
         if (if0.ram_write) ram0[if0.ram_addr] <= if0.ram_din;
         if (if0.ram_read)  ram0_dout <= ram0[if0.ram_addr];
         if (if1.ram_write) ram1[if1.ram_addr] <= if1.ram_din;
         if (if1.ram_read)  ram1_dout <= ram1[if1.ram_addr];
      end
   end

   always @(negedge clock) begin
      if (if0.ram_write) begin
         wr_cnt++;
         wr_addr = if0.ram_addr;
         wr_data = if0.ram_din;
      end
      if (if0.ram_read) rd_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One request through the selected controller; returns clock edges from accept to handshake inclusive.
   task automatic txn(input bit s, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input int hold, input int exp_lat, output int cycles);
      int   n;
      int   lat;
      exp_t e;
      logic [8:0] idx;
      sel = s;
      n = 0;
      while (!o_req_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      check("req_ready_before_accept", 32'(o_req_ready), 32'd1);
      idx = a[8:0];
      if (!s && a[31:9] != 23'd0) begin
         e.rdata = '0;
         e.err   = 1'b1;
      end else begin
         e.err = 1'b0;
         if (w) begin
            e.rdata = '0;
            if (s) model1[idx] = d;
            else   model0[idx] = d;
         end else begin
            e.rdata = s ? model1[idx] : model0[idx];
         end
      end
      sb.push_back(e);
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_valid = 1'b1;
      rsp_ready = (hold == 0);
      @(posedge clock);
      cycles = 1;
      lat = 1;
      @(negedge clock);
      req_valid = 1'b0;
      while (!o_rsp_valid && lat < 20) begin
         @(posedge clock);
         lat++;
         cycles++;
         @(negedge clock);
      end
      check("latency", 32'(lat), 32'(exp_lat));
      e = sb.pop_front();
      check("rsp_rdata", o_rsp_rdata, e.rdata);
      check("rsp_err", 32'(o_rsp_err), 32'(e.err));
      for (int k = 0; k < hold; k++) begin
         @(posedge clock);
         cycles++;
         @(negedge clock);
         check("held_rsp_valid", 32'(o_rsp_valid), 32'd1);
         check("held_rsp_rdata", o_rsp_rdata, e.rdata);
         check("held_req_ready", 32'(o_req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clock);
      cycles++;
      @(negedge clock);
      check("post_handshake_rsp_valid", 32'(o_rsp_valid), 32'd0);
      check("post_handshake_req_ready", 32'(o_req_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before end of test");
      $fatal(1, "timeout");
   end

   initial begin
      int cyc;
      int total;
      int wr0;
      int rd0;

      for (int i = 0; i < 512; i++) begin
         model0[i] = init0(i);
         model1[i] = init1(i);
      end
      clear = 1'b0;
      @(posedge clock);
      @(negedge clock);
      ram_init = 1'b0;

      check("reset_req_ready", 32'(if0.req_ready), 32'd1);
      check("reset_rsp_valid", 32'(if0.rsp_valid), 32'd0);
      check("reset_rsp_rdata", if0.rsp_rdata, 32'd0);
      check("reset_rsp_err", 32'(if0.rsp_err), 32'd0);
      check("reset_ram_read", 32'(if0.ram_read), 32'd0);
      check("reset_ram_write", 32'(if0.ram_write), 32'd0);
      check("reset_ram_addr", 32'(if0.ram_addr), 32'd0);
      check("reset_ram_din", if0.ram_din, 32'd0);
      clear = 1'b1;
      @(negedge clock);

      wr0 = wr_cnt;
      txn(1'b0, 1'b1, 32'h005, 32'hDEAD_BEEF, 0, 2, cyc);
      check("store_write_pulses", 32'(wr_cnt - wr0), 32'd1);
      check("store_write_addr", 32'(wr_addr), 32'h005);
      check("store_write_data", wr_data, 32'hDEAD_BEEF);

      wr0 = wr_cnt;
      txn(1'b0, 1'b0, 32'h005, 32'h0, 0, 3, cyc);
      check("load_no_write", 32'(wr_cnt - wr0), 32'd0);

      txn(1'b0, 1'b0, 32'h1FF, 32'h0, 5, 3, cyc);

      wr0 = wr_cnt;
      rd0 = rd_cnt;
      txn(1'b0, 1'b0, 32'h200, 32'h0, 0, 1, cyc);
      check("range_err_no_write", 32'(wr_cnt - wr0), 32'd0);
      check("range_err_no_read", 32'(rd_cnt - rd0), 32'd0);

      txn(1'b1, 1'b0, 32'h200, 32'h0, 0, 3, cyc);
      sel = 1'b0;

      // Store cut short by reset while it is in ISSUE.
      req_write = 1'b1;
      req_addr  = 32'h010;
      req_wdata = 32'hCAFE_F00D;
      req_valid = 1'b1;
      rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      check("abort_write_before_clear", 32'(if0.ram_write), 32'd1);
      check("abort_addr_before_clear", 32'(if0.ram_addr), 32'h010);
      #1;
      clear = 1'b0;
      #1;
      check("abort_write_after_clear", 32'(if0.ram_write), 32'd0);
      @(negedge clock);
      clear = 1'b1;
      @(negedge clock);
      check("abort_req_ready", 32'(if0.req_ready), 32'd1);
      check("abort_rsp_valid", 32'(if0.rsp_valid), 32'd0);
      txn(1'b0, 1'b0, 32'h010, 32'h0, 0, 3, cyc);

      total = 0;
      for (int i = 0; i < 16; i++) begin
         txn(1'b0, 1'b1, 32'(i), 32'h5A00_0000 + 32'(i) * 32'h0101_0101, 0, 2, cyc);
         total += cyc;
      end
      check("store_burst_cycles", 32'(total), 32'd48);
      total = 0;
      for (int i = 0; i < 16; i++) begin
         txn(1'b0, 1'b0, 32'(i), 32'h0, 0, 3, cyc);
         total += cyc;
      end
      check("load_burst_cycles", 32'(total), 32'd64);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
